// File: rtl/sprite_ram_writer_if.sv
// Bundle of the command, byte-stream and RAM write-port signals of sprite_ram_writer.
// master: the requester (game logic / loader); slave: the writer itself, which
// also drives the RAM write side (we / addr_w / din) and the status flags.
interface sprite_ram_writer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [ADDR_WIDTH:0]   cmd_len;
    logic [DATA_WIDTH-1:0] cmd_color;
    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [DATA_WIDTH-1:0] din;
    logic                  busy;
    logic                  done;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_len, cmd_color, s_data, s_valid,
        input  cmd_ready, s_ready, we, addr_w, din, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_len, cmd_color, s_data, s_valid,
        output cmd_ready, s_ready, we, addr_w, din, busy, done
    );
endinterface

// File: rtl/sprite_ram_writer.sv
// Command-driven write-port master for the dual-port sprite bitmap RAM.
// FILL writes a constant colour over an address range; LOAD unpacks a byte
// stream LSB-first into consecutive pixels. Addresses wrap modulo 2**ADDR_WIDTH.
// Optional build macro SPRITE_WR_TRANSPARENT_EN: LOAD skips (we=0) pixels of
// value 0 while still advancing address and counters.
module sprite_ram_writer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    sprite_ram_writer_if.slave bus
);
    localparam int                  PIX_PER_BYTE = 8 / DATA_WIDTH;
    localparam logic [3:0]          PIX_LOAD     = 4'(PIX_PER_BYTE);
    localparam logic [ADDR_WIDTH:0] LEN_MAX      = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LEN_ONE      = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {IDLE, FILL, FETCH, UNPACK, DONE} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] color_q, color_nx;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nx;
    logic [ADDR_WIDTH:0]   remaining, remaining_nx;
    logic [3:0]            pix_cnt, pix_cnt_nx;
    logic [7:0]            shreg, shreg_nx;
    logic [ADDR_WIDTH:0]   len_clip;
    logic                  issue;
    logic                  issue_we;
    logic [DATA_WIDTH-1:0] issue_din;
    logic                  ready;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  done_q;

    assign len_clip = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;

    // The done pulse is registered one cycle behind the DONE state, so the
    // writer stays busy (not ready) through that pulse cycle.
    assign ready         = (state == IDLE) && !done_q;
    assign bus.cmd_ready = ready;
    assign bus.busy      = !ready;
    assign bus.s_ready   = (state == FETCH);
    assign bus.we        = we_q;
    assign bus.addr_w    = addr_q;
    assign bus.din       = din_q;
    assign bus.done      = done_q;

    // State and working registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            color_q   <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            pix_cnt   <= '0;
            shreg     <= '0;
        end else begin
            state     <= state_nx;
            color_q   <= color_nx;
            cur_addr  <= cur_addr_nx;
            remaining <= remaining_nx;
            pix_cnt   <= pix_cnt_nx;
            shreg     <= shreg_nx;
        end
    end

    // Next-state logic and write issue decode
    always_comb begin
        state_nx     = state;
        color_nx     = color_q;
        cur_addr_nx  = cur_addr;
        remaining_nx = remaining;
        pix_cnt_nx   = pix_cnt;
        shreg_nx     = shreg;
        issue        = 1'b0;
        issue_we     = 1'b0;
        issue_din    = color_q;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && ready) begin
                    color_nx     = bus.cmd_color;
                    cur_addr_nx  = bus.cmd_base;
                    remaining_nx = len_clip;
                    if (len_clip == '0)   state_nx = DONE;
                    else if (bus.cmd_op)  state_nx = FETCH;
                    else                  state_nx = FILL;
                end
            end
            FILL: begin
                issue        = 1'b1;
                issue_we     = 1'b1;
                cur_addr_nx  = cur_addr + ADDR_WIDTH'(1);
                remaining_nx = remaining - LEN_ONE;
                if (remaining == LEN_ONE) state_nx = DONE;
            end
            FETCH: begin
                if (bus.s_valid) begin
                    shreg_nx   = bus.s_data;
                    pix_cnt_nx = PIX_LOAD;
                    state_nx   = UNPACK;
                end
            end
            UNPACK: begin
                issue     = 1'b1;
                issue_din = shreg[DATA_WIDTH-1:0];
`ifdef SPRITE_WR_TRANSPARENT_EN
                issue_we  = (shreg[DATA_WIDTH-1:0] != '0);
`else
                issue_we  = 1'b1;
`endif
                shreg_nx     = shreg >> DATA_WIDTH;
                cur_addr_nx  = cur_addr + ADDR_WIDTH'(1);
                remaining_nx = remaining - LEN_ONE;
                pix_cnt_nx   = pix_cnt - 4'd1;
                if (remaining == LEN_ONE) state_nx = DONE;
                else if (pix_cnt == 4'd1) state_nx = FETCH;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Registered RAM write port and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            done_q <= 1'b0;
        end else begin
            we_q   <= issue && issue_we;
            done_q <= (state == DONE);
            if (issue) begin
                addr_q <= cur_addr;
                din_q  <= issue_din;
            end
        end
    end
endmodule
